calc_core_param: RTL

- Parametrised arithmetic core for the calculator project; successor to the fixed 8-bit datapath.
- Accepts one operation per valid/ready transaction and returns a 2*WIDTH result plus flags through a valid/ready output.
- ADD, SUB and logic ops complete in one cycle. MUL uses an iterative shift-add and DIV a restoring divider, each taking WIDTH cycles.
- Sits between the pin-decode logic (ui_in/uio_in) and the output mux driving uo_out.

---
 rtl/calc_core_param.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/calc_core_param.sv
// Parametrised calculator core: one-cycle ALU ops, iterative shift-add MUL and restoring DIV.
// Optional accumulator operand source is built when CALC_ACCUM_EN is defined.
module calc_core_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 flag_zero,
    output logic                 flag_carry,
    output logic                 flag_dbz,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_PASS
    } op_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 zero_q, zero_d, carry_q, carry_d, dbz_q, dbz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]     opa;
    op_t                  op_w;

`ifdef CALC_ACCUM_EN
    logic [WIDTH-1:0]     acc_q, acc_d;
    assign opa = acc_sel ? acc_q : a;
`else
    logic                 unused_acc_sel;
    assign unused_acc_sel = acc_sel;
    assign opa = a;
`endif

    assign op_w = op_t'(op);

    logic [WIDTH:0]       add_s, sub_s, mul_s, div_sh;
    logic [WIDTH-1:0]     mul_addend, mul_hi_n, mul_lo_n, div_rem_n, div_lo_n;
    logic                 div_ok, last_step;
    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_carry;

    assign add_s = {1'b0, opa} + {1'b0, b};
    assign sub_s = {1'b0, opa} - {1'b0, b};

    // MUL: {hi,lo} holds partial product and remaining multiplier bits, shifted right each step
    assign mul_addend = lo_q[0] ? opnd_q : '0;
    assign mul_s      = {1'b0, hi_q} + {1'b0, mul_addend};
    assign mul_hi_n   = mul_s[WIDTH:1];
    assign mul_lo_n   = {mul_s[0], lo_q[WIDTH-1:1]};

    // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
    assign div_sh    = {hi_q, lo_q[WIDTH-1]};
    assign div_ok    = div_sh >= {1'b0, opnd_q};
    assign div_rem_n = div_ok ? WIDTH'(div_sh - {1'b0, opnd_q}) : div_sh[WIDTH-1:0];
    assign div_lo_n  = {lo_q[WIDTH-2:0], div_ok};

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_w)
            OP_ADD:  begin alu_res = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]}; alu_carry = add_s[WIDTH]; end
            OP_SUB:  begin alu_res = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]}; alu_carry = sub_s[WIDTH]; end
            OP_AND:  alu_res = {{WIDTH{1'b0}}, opa & b};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, opa | b};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, opa ^ b};
            OP_DIV:  alu_res = {opa, {WIDTH{1'b1}}};
            default: alu_res = {{WIDTH{1'b0}}, opa};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
`ifdef CALC_ACCUM_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = '0;
                    hi_d  = '0;
                    if (op_w == OP_MUL) begin
                        lo_d    = b;
                        opnd_d  = opa;
                        state_d = MUL_RUN;
                    end else if (op_w == OP_DIV && b != '0) begin
                        lo_d    = opa;
                        opnd_d  = b;
                        state_d = DIV_RUN;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        carry_d  = alu_carry;
                        dbz_d    = (op_w == OP_DIV);
                        state_d  = DONE;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == MUL_RUN) begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end else begin
                    hi_d = div_rem_n;
                    lo_d = div_lo_n;
                end
                if (last_step) begin
                    result_d = {hi_d, lo_d};
                    zero_d   = ({hi_d, lo_d} == '0);
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef CALC_ACCUM_EN
                    acc_d   = result_q[WIDTH-1:0];
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
`ifdef CALC_ACCUM_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
`ifdef CALC_ACCUM_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == MUL_RUN) || (state_q == DIV_RUN);
    assign result     = result_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_dbz   = dbz_q;

endmodule
